// File: rtl/bram_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-port byte-enable block RAM.
// Read data returns through per-port credit-managed response FIFOs; define BRAM_ARB_PERF_EN for perf counters.
module bram_port_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = DATA_WIDTH/8,
  parameter int RSP_DEPTH  = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic                  req0_we,
  input  logic [BE_WIDTH-1:0]   req0_be,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic                  req1_we,
  input  logic [BE_WIDTH-1:0]   req1_be,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  rsp0_valid,
  input  logic                  rsp0_ready,
  output logic [DATA_WIDTH-1:0] rsp0_data,
  output logic                  rsp1_valid,
  input  logic                  rsp1_ready,
  output logic [DATA_WIDTH-1:0] rsp1_data,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_di,
  output logic                  ram_we,
  output logic                  ram_re,
  output logic [BE_WIDTH-1:0]   ram_be,
  input  logic [DATA_WIDTH-1:0] ram_do
`ifdef BRAM_ARB_PERF_EN
  ,
  output logic [31:0]           perf0_grants,
  output logic [31:0]           perf1_grants,
  output logic [31:0]           perf_conflicts
`endif
);

  localparam logic [2:0] CRED_MAX = 3'(RSP_DEPTH);

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'(RSP_DEPTH-1)) ? 2'd0 : p + 2'd1;
  endfunction

  logic [1:0]            req_vld, req_wr, rsp_rdy, rsp_vld, pop, elig, gnt, rd_gnt;
  logic [DATA_WIDTH-1:0] rsp_dat [2];
  logic                  last_grant, gsel, gnt_any, both_elig;
  logic                  inflight_vld_p1, inflight_port_p1;

  assign req_vld = {req1_valid, req0_valid};
  assign req_wr  = {req1_we, req0_we};
  assign rsp_rdy = {rsp1_ready, rsp0_ready};

  assign rsp0_valid = rsp_vld[0];
  assign rsp1_valid = rsp_vld[1];
  assign rsp0_data  = rsp_dat[0];
  assign rsp1_data  = rsp_dat[1];

  // Stage p0: combinational arbitration and RAM drive
  assign both_elig = elig[0] & elig[1];
  assign gsel      = both_elig ? ~last_grant : elig[1];
  assign gnt_any   = ~RST & (elig != 2'b00);
  assign gnt       = {gnt_any & gsel, gnt_any & ~gsel};
  assign rd_gnt    = gnt & ~req_wr;

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];

  assign ram_addr = gsel ? req1_addr  : req0_addr;
  assign ram_di   = gsel ? req1_wdata : req0_wdata;
  assign ram_be   = gsel ? req1_be    : req0_be;
  assign ram_we   = |(gnt & req_wr);
  assign ram_re   = |rd_gnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      last_grant      <= 1'b1;
      inflight_vld_p1 <= 1'b0;
    end else begin
      if (gnt_any) last_grant <= gsel;
      inflight_vld_p1 <= ram_re;
    end
  end

  always_ff @(posedge CLK) begin
    inflight_port_p1 <= gsel;
  end

  // Stage p1: RAM output captured into the issuing port's FIFO
  for (genvar n = 0; n < 2; n++) begin : g_port
    logic [2:0]            cred, cnt;
    logic [1:0]            wp, rp;
    logic                  push;
    logic [DATA_WIDTH-1:0] mem [4];

    assign push       = inflight_vld_p1 & (inflight_port_p1 == 1'(n));
    assign rsp_vld[n] = (cnt != 3'd0);
    assign pop[n]     = rsp_vld[n] & rsp_rdy[n];
    // A pop in the same cycle frees a credit early, keeping reads back-to-back.
    assign elig[n]    = req_vld[n] & (req_wr[n] | (cred != 3'd0) | pop[n]);
    assign rsp_dat[n] = mem[rp];

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        cred <= CRED_MAX;
        cnt  <= 3'd0;
        wp   <= 2'd0;
        rp   <= 2'd0;
      end else begin
        if (push)   wp <= ptr_inc(wp);
        if (pop[n]) rp <= ptr_inc(rp);
        case ({push, pop[n]})
          2'b10:   cnt <= cnt + 3'd1;
          2'b01:   cnt <= cnt - 3'd1;
          default: cnt <= cnt;
        endcase
        case ({rd_gnt[n], pop[n]})
          2'b10:   cred <= cred - 3'd1;
          2'b01:   cred <= cred + 3'd1;
          default: cred <= cred;
        endcase
      end
    end

    always_ff @(posedge CLK) begin
      if (push) mem[wp] <= ram_do;
    end

    a_cred_under: assert property (@(posedge CLK) disable iff (RST)
      !(rd_gnt[n] && !pop[n] && cred == 3'd0));
    a_cred_over: assert property (@(posedge CLK) disable iff (RST)
      !(pop[n] && !rd_gnt[n] && cred == CRED_MAX));
    a_fifo_full: assert property (@(posedge CLK) disable iff (RST)
      !(push && !pop[n] && cnt == CRED_MAX));
  end

`ifdef BRAM_ARB_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      perf0_grants   <= 32'd0;
      perf1_grants   <= 32'd0;
      perf_conflicts <= 32'd0;
    end else begin
      if (gnt[0])    perf0_grants   <= sat_inc(perf0_grants);
      if (gnt[1])    perf1_grants   <= sat_inc(perf1_grants);
      if (both_elig) perf_conflicts <= sat_inc(perf_conflicts);
    end
  end
`endif

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: RAM model, directed scenarios, then random traffic
// checked every cycle against a queue-based reference of arbitration and responses.
module tb_bram_port_arbiter;
  localparam int AW = 10, DW = 32, BW = 4, DEPTH = 2;

  logic          CLK, RST;
  logic          req0_valid, req0_ready, req0_we, req1_valid, req1_ready, req1_we;
  logic [AW-1:0] req0_addr, req1_addr, ram_addr;
  logic [BW-1:0] req0_be, req1_be, ram_be;
  logic [DW-1:0] req0_wdata, req1_wdata, rsp0_data, rsp1_data, ram_di, ram_do;
  logic          rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready, ram_we, ram_re;
`ifdef BRAM_ARB_PERF_EN
  logic [31:0]   perf0_grants, perf1_grants, perf_conflicts;
`endif

  bram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .RSP_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_we(req0_we),
    .req0_be(req0_be), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_we(req1_we),
    .req1_be(req1_be), .req1_wdata(req1_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .ram_addr(ram_addr), .ram_di(ram_di), .ram_we(ram_we), .ram_re(ram_re), .ram_be(ram_be),
    .ram_do(ram_do)
`ifdef BRAM_ARB_PERF_EN
    , .perf0_grants(perf0_grants), .perf1_grants(perf1_grants), .perf_conflicts(perf_conflicts)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Registered single-port RAM
  logic [DW-1:0] ram_mem [1<<AW];
  initial begin
    for (int i = 0; i < (1<<AW); i++) ram_mem[i] = '0;
    ram_do <= '0;
    forever begin
      @(posedge CLK);
      if (ram_re) ram_do <= ram_mem[ram_addr];
      if (ram_we)
        for (int b = 0; b < BW; b++)
          if (ram_be[b]) ram_mem[ram_addr][8*b +: 8] = ram_di[8*b +: 8];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model state
  typedef struct { logic [DW-1:0] d; int due; } rsp_t;
  logic [DW-1:0] shadow [1<<AW];
  rsp_t          q0[$], q1[$];
  logic          m_last;
  int            cyc, vectors, miscompares;
  logic          ob_r0v, ob_r1v, ob_rdy0, ob_rdy1;
  logic [DW-1:0] ob_r0d, ob_r1d;
  int            ob_g;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req0_we = 0; req0_addr = '0; req0_be = '0; req0_wdata = '0;
    req1_valid = 0; req1_we = 0; req1_addr = '0; req1_be = '0; req1_wdata = '0;
    rsp0_ready = 1; rsp1_ready = 1;
  endtask

  // One cycle: predict and check outputs at the falling edge, then advance the model.
  task automatic step();
    logic [1:0]    vx, px, el;
    logic          ga, gs, gw;
    logic [AW-1:0] ga_a;
    logic [BW-1:0] ga_be;
    logic [DW-1:0] ga_wd;
    rsp_t          e;
    @(negedge CLK);
    vx[0] = (q0.size() > 0) && (q0[0].due <= cyc);
    vx[1] = (q1.size() > 0) && (q1[0].due <= cyc);
    px    = vx & {rsp1_ready, rsp0_ready};
    el[0] = req0_valid && (req0_we || (q0.size() < DEPTH) || px[0]);
    el[1] = req1_valid && (req1_we || (q1.size() < DEPTH) || px[1]);
    ga    = (el != 2'b00);
    gs    = (el == 2'b11) ? ~m_last : el[1];
    gw    = gs ? req1_we    : req0_we;
    ga_a  = gs ? req1_addr  : req0_addr;
    ga_be = gs ? req1_be    : req0_be;
    ga_wd = gs ? req1_wdata : req0_wdata;
    chk1("rsp0_valid", rsp0_valid, vx[0]);
    chk1("rsp1_valid", rsp1_valid, vx[1]);
    if (vx[0]) chkw("rsp0_data", rsp0_data, q0[0].d);
    if (vx[1]) chkw("rsp1_data", rsp1_data, q1[0].d);
    chk1("req0_ready", req0_ready, ga & ~gs);
    chk1("req1_ready", req1_ready, ga & gs);
    chk1("ram_we", ram_we, ga & gw);
    chk1("ram_re", ram_re, ga & ~gw);
    if (ga) chkw("ram_addr", 32'(ram_addr), 32'(ga_a));
    if (ga && gw) begin
      chkw("ram_di", ram_di, ga_wd);
      chkw("ram_be", 32'(ram_be), 32'(ga_be));
    end
    ob_r0v = rsp0_valid; ob_r1v = rsp1_valid; ob_r0d = rsp0_data; ob_r1d = rsp1_data;
    ob_rdy0 = req0_ready; ob_rdy1 = req1_ready;
    ob_g = ga ? int'(gs) : -1;
    if (px[0]) void'(q0.pop_front());
    if (px[1]) void'(q1.pop_front());
    if (ga) begin
      m_last = gs;
      if (gw) begin
        for (int b = 0; b < BW; b++)
          if (ga_be[b]) shadow[ga_a][8*b +: 8] = ga_wd[8*b +: 8];
      end else begin
        e.d = shadow[ga_a];
        e.due = cyc + 2;
        if (gs) q1.push_back(e); else q0.push_back(e);
      end
    end
    cyc++;
    @(posedge CLK);
    #1;
  endtask

  // Asserts reset for one edge with both ports requesting, checking the gated outputs.
  task automatic do_reset();
    RST = 1;
    req0_valid = 1; req0_we = 0; req1_valid = 1; req1_we = 1; req1_be = 4'hF;
    @(negedge CLK);
    chk1("rst req0_ready", req0_ready, 1'b0);
    chk1("rst req1_ready", req1_ready, 1'b0);
    chk1("rst ram_we", ram_we, 1'b0);
    chk1("rst ram_re", ram_re, 1'b0);
    chk1("rst rsp0_valid", rsp0_valid, 1'b0);
    chk1("rst rsp1_valid", rsp1_valid, 1'b0);
    q0.delete(); q1.delete(); m_last = 1'b1;
    @(posedge CLK);
    #1;
    RST = 0;
    idle_inputs();
    cyc++;
  endtask

  task automatic rd(input int p, input logic [AW-1:0] a);
    if (p == 0) begin req0_valid = 1; req0_we = 0; req0_addr = a; end
    else        begin req1_valid = 1; req1_we = 0; req1_addr = a; end
  endtask

  task automatic wr(input int p, input logic [AW-1:0] a, input logic [BW-1:0] be, input logic [DW-1:0] d);
    if (p == 0) begin req0_valid = 1; req0_we = 1; req0_addr = a; req0_be = be; req0_wdata = d; end
    else        begin req1_valid = 1; req1_we = 1; req1_addr = a; req1_be = be; req1_wdata = d; end
  endtask

  initial begin
    vectors = 0; miscompares = 0; cyc = 0; m_last = 1'b1;
    for (int i = 0; i < (1<<AW); i++) shadow[i] = '0;
    idle_inputs();
    RST = 0;
    #1;
    do_reset();

    // Port 0 full write then read back
    wr(0, 10'd5, 4'hF, 32'hA5A5A5A5); step();
    chk1("t1 write accepted", ob_rdy0, 1'b1);
    rd(0, 10'd5); step();
    chk1("t1 read accepted", ob_rdy0, 1'b1);
    idle_inputs(); step();
    chk1("t1 rsp0 not yet", ob_r0v, 1'b0);
    step();
    chk1("t1 rsp0 at +2", ob_r0v, 1'b1);
    chkw("t1 rsp0 data", ob_r0d, 32'hA5A5A5A5);
    chk1("t1 rsp1 silent", ob_r1v, 1'b0);
    step();

    // Port 1 partial-byte write merge
    wr(1, 10'd5, 4'hF, 32'h11223344); step();
    wr(1, 10'd5, 4'h2, 32'h0000FF00); step();
    rd(1, 10'd5); step();
    idle_inputs(); step(); step();
    chk1("t2 rsp1 valid", ob_r1v, 1'b1);
    chkw("t2 rsp1 data", ob_r1d, 32'h1122FF44);
    chk1("t2 rsp0 silent", ob_r0v, 1'b0);
    step();

    // Contention: alternating grants starting with port 0
    wr(0, 10'd1, 4'hF, 32'h11110001); step();
    idle_inputs();
    wr(1, 10'd2, 4'hF, 32'h22220002); step();
    idle_inputs();
    do_reset();
    rd(0, 10'd1); rd(1, 10'd2);
    for (int i = 0; i < 8; i++) begin
      step();
      chkw("t3 grant order", 32'(ob_g), 32'(i % 2));
      if (ob_r0v) chkw("t3 rsp0 own data", ob_r0d, 32'h11110001);
      if (ob_r1v) chkw("t3 rsp1 own data", ob_r1d, 32'h22220002);
    end
    idle_inputs();
    for (int i = 0; i < 4; i++) step();

    // Credit exhaustion with rsp0 stalled
    rsp0_ready = 0; rd(0, 10'd1);
    step(); chk1("t4 read1 accepted", ob_rdy0, 1'b1);
    step(); chk1("t4 read2 accepted", ob_rdy0, 1'b1);
    step(); chk1("t4 read3 blocked", ob_rdy0, 1'b0);
    rsp0_ready = 1;
    step();
    chk1("t4 read3 released", ob_rdy0, 1'b1);
    chk1("t4 pop same cycle", ob_r0v, 1'b1);
    idle_inputs();
    for (int i = 0; i < 5; i++) step();

    // Reset the cycle after a read grant drops the read
    rd(0, 10'd5); step();
    chk1("t5 read accepted", ob_rdy0, 1'b1);
    idle_inputs();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step();
      chk1("t5 dropped rsp", ob_r0v, 1'b0);
    end
    rsp0_ready = 0; rd(0, 10'd5);
    step(); chk1("t5 cred read1", ob_rdy0, 1'b1);
    step(); chk1("t5 cred read2", ob_rdy0, 1'b1);
    step(); chk1("t5 cred exhausted", ob_rdy0, 1'b0);
    chk1("t5 first rsp valid", ob_r0v, 1'b1);
    chkw("t5 first rsp data", ob_r0d, 32'h1122FF44);
    idle_inputs();
    for (int i = 0; i < 5; i++) step();

`ifdef BRAM_ARB_PERF_EN
    do_reset();
    @(negedge CLK);
    chkw("perf_conflicts reset", perf_conflicts, 32'd0);
    @(posedge CLK); #1; cyc++;
    rd(0, 10'd1); rd(1, 10'd2);
    for (int i = 0; i < 10; i++) step();
    idle_inputs();
    for (int i = 0; i < 4; i++) step();
    chkw("perf_conflicts", perf_conflicts, 32'd10);
    chkw("perf0_grants", perf0_grants, 32'd5);
    chkw("perf1_grants", perf1_grants, 32'd5);
`endif

    // Random traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      req0_valid = ($urandom_range(0, 9) < 6);
      req0_we    = ($urandom_range(0, 9) < 3);
      req0_addr  = 10'($urandom_range(0, 15));
      req0_be    = 4'($urandom);
      req0_wdata = $urandom;
      req1_valid = ($urandom_range(0, 9) < 6);
      req1_we    = ($urandom_range(0, 9) < 3);
      req1_addr  = 10'($urandom_range(0, 15));
      req1_be    = 4'($urandom);
      req1_wdata = $urandom;
      rsp0_ready = ($urandom_range(0, 9) < 7);
      rsp1_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    idle_inputs();
    for (int i = 0; i < 6; i++) step();
    chkw("q0 drained", 32'(q0.size()), 32'd0);
    chkw("q1 drained", 32'(q1.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Shares one single-port byte-enable block RAM between two requesters, e.g. instruction fetch (port 0) and load/store (port 1).
- Grants one RAM access per cycle using round-robin arbitration.
- Drives the RAM address, data, WE, RE and BE lines directly; the RAM registers them.
- Routes each RAM read result back to the port that issued the read, through a small response FIFO per port with credit-based flow control.

Parameters:
- ADDR_WIDTH, 10, RAM word-address width.
- DATA_WIDTH, 32, RAM word width; must be a multiple of 8.
- BE_WIDTH, DATA_WIDTH/8, byte-enable width.
- RSP_DEPTH, 2, entries per response FIFO; also the read credits per port; legal values 1..4.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- reqN_valid  in  1  (N=0,1) request present.
- reqN_ready  out  1  request accepted this cycle; combinational grant.
- reqN_addr  in  ADDR_WIDTH  word address.
- reqN_we  in  1  1 = write, 0 = read.
- reqN_be  in  BE_WIDTH  byte enables; used for writes only.
- reqN_wdata  in  DATA_WIDTH  write data.
- rspN_valid  out  1  read data available.
- rspN_ready  in  1  requester consumes the response.
- rspN_data  out  DATA_WIDTH  read data.
- ram_addr  out  ADDR_WIDTH  RAM address.
- ram_di  out  DATA_WIDTH  RAM write data.
- ram_we  out  1  RAM write enable.
- ram_re  out  1  RAM read enable.
- ram_be  out  BE_WIDTH  RAM byte enables.
- ram_do  in  DATA_WIDTH  RAM read data; valid one cycle after ram_re.

Behaviour:
- Eligibility:
  - A write from port N is eligible whenever reqN_valid=1.
  - A read from port N is eligible when reqN_valid=1 and (credN>0 or a rspN pop occurs this cycle).
- Arbitration:
  - At most one grant per cycle.
  - If exactly one port is eligible, that port is granted.
  - If both are eligible, the port other than last_grant is granted.
  - last_grant updates only on a grant; reset value = 1, so port 0 wins the first conflict.
- RAM drive, all combinational from the granted request:
  - ram_addr, ram_di and ram_be come from the granted request.
  - ram_we = grant & we; ram_re = grant & ~we.
  - ram_we and ram_re are never both 1, because the RAM returns X on simultaneous WE/RE.
  - With no grant: ram_we=0, ram_re=0; ram_addr, ram_di and ram_be are don't-care.
- Read pipeline:
  - A read granted in cycle t sets inflight_valid and inflight_port at the end of t.
  - In t+1, ram_do is pushed into FIFO[inflight_port].
  - rspN_valid rises in t+2; read latency is 2 cycles from accept to rspN_valid.
- Credits:
  - credN resets to RSP_DEPTH.
  - A read grant decrements credN; a rspN handshake (rspN_valid & rspN_ready) increments it.
  - When both occur in the same cycle, credN is unchanged.
  - credN never underflows or overflows; this is asserted in simulation.
- FIFOs:
  - First-in first-out per port; rspN_data is the FIFO head, registered.
  - A push to a full FIFO cannot occur because of credits.
  - Pop and push in the same cycle are both performed.
- Writes produce no response and consume no credit. Data written at t is visible to a read granted at t+1 or later.
- Back-to-back reads on one port with rspN_ready held at 1 sustain one read per cycle when RSP_DEPTH>=2.
- Reset (any time, including mid-operation):
  - Any in-flight read is dropped and the FIFOs are cleared.
  - rspN_valid=0, credN=RSP_DEPTH, last_grant=1.
  - While RST=1: reqN_ready=0, ram_we=0, ram_re=0.

Optional Feature:
- Macro BRAM_ARB_PERF_EN.
- Defined:
  - Adds outputs perfN_grants (32-bit, grants to port N) and perf_conflicts (32-bit, cycles where both ports were eligible).
  - Counters saturate at all-ones and reset to 0.
- Undefined: the outputs and counters are absent; all other behaviour is identical.

Test Plan:
- Port 0 writes addr 5, data 0xA5A5A5A5, be 0xF; then reads addr 5 → rsp0_valid two cycles after accept, data 0xA5A5A5A5; port 1 sees no response.
- Port 1 writes addr 5, be 0x2, data 0x0000FF00 over 0x11223344; then reads → 0x1122FF44.
- Both ports continuously issue reads to addrs 1 and 2 → grants alternate 0,1,0,1 starting with port 0; each port receives only its own data, in order.
- Port 0 has rsp0_ready=0 and issues 3 reads → only 2 accepted (req0_ready low on the 3rd); raising rsp0_ready releases the 3rd on the same cycle as the first pop.
- RST asserted the cycle after a read grant → no response ever appears; after release, cred0 is 2 and the first read completes normally.
- With BRAM_ARB_PERF_EN defined, 10 cycles of contention → perf_conflicts=10, perf0_grants=5, perf1_grants=5.
